// File: rtl/logic_e_cfg_serial.sv
// Configurable logic element: serially loaded shadow config, atomic commit to the
// active config, and a selectable combinational or registered output.
module logic_e_cfg_serial #(
  parameter int N_INPUTS = 35,
  parameter int SEL_W    = 6,
  parameter int CFG_W    = 2*SEL_W+4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  output logic                cfg_ready,
  output logic                cfg_full,
  input  logic                cfg_commit,
  output logic                cfg_err,
  input  logic [N_INPUTS-1:0] all_inputs,
  output logic                le_out
);

  localparam int CNT_W = $clog2(CFG_W+1);

  typedef enum logic {S_LOAD, S_FULL} state_t;

  state_t            r_state, w_state_nxt;
  logic [CFG_W-1:0]  r_shadow;
  logic [CFG_W-1:0]  r_active;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_le_q;
  logic              w_accept;
  logic              w_commit_ok;
  logic              w_commit_bad;
  logic              w_a;
  logic              w_b;
  logic              w_le_comb;

  // Selects beyond the bus width read as 0, so le_out never goes X.
  function automatic logic sel_operand(input logic [N_INPUTS-1:0] bus,
                                       input logic [SEL_W-1:0]    sel);
    logic v;
    v = 1'b0;
    for (int i = 0; i < N_INPUTS; i++)
      if (sel == SEL_W'(i)) v = bus[i];
    return v;
  endfunction

  function automatic logic le_func(input logic [2:0] func, input logic a, input logic b);
    logic y;
    case (func)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~a;
      3'd3:    y = a ^ b;
      3'd4:    y = ~(a ^ b);
      3'd5:    y = ~(a & b);
      3'd6:    y = ~(a | b);
      default: y = a;
    endcase
    return y;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_commit_ok  = 1'b0;
    w_commit_bad = 1'b0;
    cfg_ready    = 1'b0;
    cfg_full     = 1'b0;
    case (r_state)
      S_LOAD: begin
        cfg_ready    = 1'b1;
        w_accept     = cfg_valid;
        w_commit_bad = cfg_commit;
        if (cfg_valid && (r_cnt == CNT_W'(CFG_W-1))) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        cfg_full = 1'b1;
        if (cfg_commit) begin
          w_commit_ok = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_LOAD;
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_shadow <= {r_shadow[CFG_W-2:0], cfg_bit};
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_commit_ok) begin
        r_active <= r_shadow;
        r_shadow <= '0;
        r_cnt    <= '0;
      end
      if (w_commit_bad) r_err <= 1'b1;
    end
  end

  assign w_a       = sel_operand(all_inputs, r_active[SEL_W-1:0]);
  assign w_b       = sel_operand(all_inputs, r_active[2*SEL_W-1:SEL_W]);
  assign w_le_comb = le_func(r_active[CFG_W-2:CFG_W-4], w_a, w_b);

  // Output register stage: always tracks le_comb, reg_en only picks the source.
  always_ff @(posedge clk) begin
    if (rst) r_le_q <= 1'b0;
    else     r_le_q <= w_le_comb;
  end

  assign le_out  = r_active[CFG_W-1] ? r_le_q : w_le_comb;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_logic_e_cfg_serial.sv
// Randomised and directed bench for logic_e_cfg_serial against a queue-based reference model.
module tb_logic_e_cfg_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_commit = 1'b0;
  logic [34:0] all_inputs = '0;
  logic        cfg_ready, cfg_full, cfg_err, le_out;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending bits as a queue, committed word, sticky error, registered output.
  bit          m_bits[$];
  logic [15:0] m_active = '0;
  logic        m_err = 1'b0;
  logic        m_q = 1'b0;

  logic_e_cfg_serial dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_full(cfg_full), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .all_inputs(all_inputs), .le_out(le_out)
  );

  always #5 clk = ~clk;

  function automatic logic mdl_eval(input logic [15:0] cfg, input logic [34:0] in);
    int unsigned sa, sb;
    logic [34:0] sh;
    logic a, b;
    sa = int'(cfg[5:0]);
    sb = int'(cfg[11:6]);
    sh = in >> sa;
    a  = (sa < 35) ? sh[0] : 1'b0;
    sh = in >> sb;
    b  = (sb < 35) ? sh[0] : 1'b0;
    case (cfg[14:12])
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return !a;
      3'd3: return a != b;
      3'd4: return a == b;
      3'd5: return !(a & b);
      3'd6: return !(a | b);
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_out;
    exp_out = m_active[15] ? m_q : mdl_eval(m_active, all_inputs);
    chk({tag, ":ready"}, cfg_ready, m_bits.size() != 16);
    chk({tag, ":full"},  cfg_full,  m_bits.size() == 16);
    chk({tag, ":err"},   cfg_err,   m_err);
    chk({tag, ":le_out"}, le_out,   exp_out);
  endtask

  task automatic tick();
    logic nq;
    logic [15:0] w;
    nq = mdl_eval(m_active, all_inputs);
    @(posedge clk);
    #1;
    if (rst) begin
      m_bits.delete();
      m_active = '0;
      m_err    = 1'b0;
      m_q      = 1'b0;
    end else begin
      m_q = nq;
      if (m_bits.size() == 16) begin
        if (cfg_commit) begin
          w = '0;
          foreach (m_bits[i]) w = {w[14:0], m_bits[i]};
          m_active = w;
          m_bits.delete();
        end
      end else begin
        if (cfg_commit) m_err = 1'b1;
        if (cfg_valid) m_bits.push_back(cfg_bit);
      end
    end
  endtask

  task automatic send_bits(input logic [15:0] word, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = word[15-i];
      tick();
      check_all("shift");
    end
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check_all("commit");
  endtask

  initial begin
    logic [63:0] r;
    logic [15:0] w;

    // 1: reset state
    all_inputs[0] = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_le_out", le_out, 1'b1);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_full", cfg_full, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    all_inputs[0] = 1'b0;
    #1;
    chk("rst_le_out_follow", le_out, 1'b0);
    check_all("t1");

    // 2: XOR, comb mode
    all_inputs = '0;
    all_inputs[1] = 1'b1;
    send_bits(16'h3081, 0, 16);
    chk("t2_full", cfg_full, 1'b1);
    commit();
    chk("t2_xor10", le_out, 1'b1);
    all_inputs[2] = 1'b1;
    #1;
    chk("t2_xor11", le_out, 1'b0);
    check_all("t2");

    // 3: AND, registered mode
    send_bits(16'h8140, 0, 16);
    all_inputs[0] = 1'b1;
    all_inputs[5] = 1'b1;
    commit();
    tick();
    check_all("t3_hold");
    all_inputs[5] = 1'b0;
    #1;
    chk("t3_at_t", le_out, 1'b1);
    tick();
    chk("t3_at_t1", le_out, 1'b0);
    check_all("t3");

    // 4: valid ignored while full, commit wins over valid
    send_bits(16'h5042, 0, 16);
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_ready_low", cfg_ready, 1'b0);
      check_all("t4_hold");
    end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_valid  = 1'b0;
    check_all("t4_commit");
    chk("t4_full_clr", cfg_full, 1'b0);
    all_inputs[1] = 1'b1;
    all_inputs[2] = 1'b1;
    #1;
    chk("t4_nand11", le_out, 1'b0);
    send_bits(16'h3081, 0, 15);
    chk("t4_cnt0_15", cfg_full, 1'b0);
    send_bits(16'h3081, 15, 1);
    chk("t4_cnt0_16", cfg_full, 1'b1);
    commit();

    // 5: premature commit sets sticky error
    w = 16'h1ABC;
    send_bits(w, 0, 10);
    commit();
    chk("t5_err", cfg_err, 1'b1);
    send_bits(w, 10, 6);
    chk("t5_full", cfg_full, 1'b1);
    commit();
    chk("t5_err_sticky", cfg_err, 1'b1);

    // 6: out-of-range select, reset mid-load
    send_bits(16'h7028, 0, 16);
    commit();
    all_inputs = '1;
    #1;
    chk("t6_sel40", le_out, 1'b0);
    send_bits(16'hFFFF, 0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("t6_rst");
    chk("t6_err_clr", cfg_err, 1'b0);
    w = 16'(($urandom()));
    send_bits(w, 0, 15);
    chk("t6_full_15", cfg_full, 1'b0);
    send_bits(w, 15, 1);
    chk("t6_full_16", cfg_full, 1'b1);
    commit();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = {$urandom(), $urandom()};
      all_inputs = r[34:0];
      rst        = ($urandom_range(0, 149) == 0);
      cfg_valid  = ($urandom_range(0, 3) != 0);
      cfg_bit    = $urandom_range(0, 1) == 1;
      cfg_commit = ($urandom_range(0, 11) == 0);
      tick();
      check_all("rnd");
      r = {$urandom(), $urandom()};
      all_inputs = r[34:0];
      #1;
      check_all("rnd_in");
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_commit = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/logic_e_cfg_serial.md
Name: logic_e_cfg_serial

Overview:
Next-generation configurable logic element for the evolvable-circuit fabric. It is parametrised in input-bus width, with the input-select width derived from it. Configuration is loaded serially into a shadow register with a valid/ready handshake and committed atomically to the active configuration. A per-element mode bit selects a combinational or registered (flip-flop) output, so the element can be chained serially and can evolve sequential circuits.

Parameters:
N_INPUTS, 35, width of the candidate input bus.
SEL_W, 6, bits per input select (ceil(log2(N_INPUTS))).
CFG_W, 2*SEL_W+4, configuration word width (derived; do not override).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
cfg_valid  in  1  serial config bit present.
cfg_bit  in  1  serial config data; first bit sent lands in MSB.
cfg_ready  out  1  element accepts a config bit this cycle.
cfg_full  out  1  shadow holds a complete CFG_W-bit word.
cfg_commit  in  1  copy shadow to active config (single-cycle pulse).
cfg_err  out  1  sticky: commit seen while not full.
all_inputs  in  N_INPUTS  candidate operand bus.
le_out  out  1  element output.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Config word layout: [CFG_W-1] reg_en; [CFG_W-2:CFG_W-4] func; [2*SEL_W-1:SEL_W] sel_b; [SEL_W-1:0] sel_a.
- Operands: a = all_inputs[sel_a], b = all_inputs[sel_b]. Any select >= N_INPUTS reads as 0.
- func codes: 0 AND, 1 OR, 2 NOT a, 3 XOR, 4 XNOR, 5 NAND, 6 NOR, 7 BUF a.
- FSM states:
  - LOAD: cfg_ready=1, cfg_full=0.
  - FULL: cfg_ready=0, cfg_full=1.
- Bit counter cnt runs 0..CFG_W.
- Shift rule: a bit is accepted only when cfg_valid && cfg_ready. On acceptance: shadow <= {shadow[CFG_W-2:0], cfg_bit}; cnt++.
- LOAD -> FULL on the edge that accepts bit number CFG_W. cfg_ready drops the next cycle.
- FULL: cfg_valid is ignored, with no shift and no count change.
- FULL + cfg_commit: active <= shadow; shadow and cnt cleared; state -> LOAD. The new function drives comb le_out in the cycle after the commit edge.
- LOAD + cfg_commit: ignored. The active config is unchanged, cfg_err <= 1 (sticky until rst), and loading continues.
- cfg_valid and cfg_commit in the same FULL cycle: commit wins and the bit is not accepted.
- Datapath: le_comb = f(a,b) from the active config, purely combinational. le_q <= le_comb on every clk edge, regardless of reg_en.
- le_out = reg_en ? le_q : le_comb.
- Registered latency: an input change appears on le_out one cycle later.
- Mode switch at commit: le_out switches source in the cycle after commit. le_q already holds the value sampled under the old config.
- Reset (any state, including mid-load):
  - shadow=0, active=0, cnt=0, state=LOAD, cfg_err=0, le_q=0.
  - Outputs after reset: cfg_ready=1, cfg_full=0, cfg_err=0.
  - Active config 0 means AND of all_inputs[0] with itself, comb mode, so le_out = all_inputs[0].
  - Any partial word is discarded.
- No X on le_out for any select value.

Test Plan:
1. Reset, all_inputs[0]=1 -> le_out=1, cfg_ready=1, cfg_full=0, cfg_err=0. Drive all_inputs[0]=0 -> le_out=0 in the same cycle.
2. Shift 0x3081 (XOR, sel_a=1, sel_b=2, comb) as 16 bits MSB-first, then pulse cfg_commit. Required: cfg_full=1 after bit 16. With in[1]=1, in[2]=0 -> le_out=1 the cycle after commit. Set in[2]=1 -> le_out=0 in the same cycle.
3. Shift 0x8140 (reg_en=1, AND, sel_a=0, sel_b=5), commit, hold in[0]=in[5]=1. Toggle in[5] to 0 at cycle t -> le_out=1 at t and falls to 0 at t+1.
4. After 16 bits, hold cfg_valid=1 with cfg_bit=1 for 3 cycles. Required: cfg_ready=0 and the shadow is unchanged. Then commit with cfg_valid=1 in the same cycle -> the commit takes effect and cnt=0 afterwards.
5. Commit after 10 bits -> cfg_err=1 and the active config is unchanged. The remaining 6 bits complete the word and the next commit succeeds; cfg_err stays 1.
6. Shift 0x7028 (BUF, sel_a=40) and commit -> le_out=0 for all_inputs all-ones. Assert rst after 7 bits of the next word, then shift a fresh full word -> a clean 16-bit load, and cfg_full rises only after 16 new bits.
